decim_buffer: RTL and testbench

DECIM_BUFFER -- requirements
Module: decim_buffer

---
 rtl/decim_buffer.sv | 196 +++++++++++++++++++
 tb/tb_decim_buffer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/decim_buffer.sv
// rtl/decim_buffer.sv - block-average decimator with a small ready/valid output FIFO
//
// Purpose:
//   Sums R = 2^shift consecutive en-qualified samples, forms the rounded
//   arithmetic mean (round half up, then >>> shift), saturates it to DW bits
//   and pushes it into a 2^AW-deep FIFO.  The FIFO head drives out_data
//   directly (no output register), so a result is visible one cycle after the
//   en edge that closes its block.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (en ignored while asserted)
//   en         sample strobe shared with the upstream filter stage
//   in         signed DW-bit sample, valid when en=1
//   shift      log2 of the decimation ratio, latched on the first en of a block
//   clr_ovf    clears the sticky overflow flag (and the drop counter)
//   out_data   FIFO head sample (don't-care while out_valid=0)
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts the head when out_valid=1
//   level      FIFO occupancy, 0..2^AW
//   ovf        sticky: a decimated result was dropped on a full FIFO
//   drop_cnt   16-bit saturating count of dropped results (optional)
//
// Build option:
//   DECIM_DROP_CNT_EN  when defined, adds the drop_cnt output and its counter.

module decim_buffer #(
  parameter int DW = 10,
  parameter int SW = 3,
  parameter int AW = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [DW-1:0] in,
  input  logic [SW-1:0]        shift,
  input  logic                 clr_ovf,
  output logic signed [DW-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AW:0]          level,
`ifdef DECIM_DROP_CNT_EN
  output logic [15:0]          drop_cnt,
`endif
  output logic                 ovf
);

  // Counter width covers the largest ratio 2^(2^SW-1); the accumulator grows
  // by the same number of bits so a full block of extreme samples cannot wrap.
  localparam int CW    = (1 << SW) - 1;
  localparam int ACCW  = DW + CW;
  localparam int SUMW  = ACCW + 1;
  localparam int DEPTH = 1 << AW;

  localparam logic signed [SUMW-1:0] SAT_MAX = SUMW'((1 << (DW - 1)) - 1);
  localparam logic signed [SUMW-1:0] SAT_MIN = -SAT_MAX - SUMW'(1);

  // Block accumulator state
  logic signed [ACCW-1:0] r_acc;
  logic [CW-1:0]          r_cnt;
  logic [SW-1:0]          r_shift;

  // FIFO state; pointers carry one extra wrap bit to tell full from empty
  logic signed [DW-1:0]   r_mem [DEPTH];
  logic [AW:0]            r_wptr;
  logic [AW:0]            r_rptr;
  logic                   r_ovf;

  logic [SW-1:0]          w_shift_eff;
  logic [CW-1:0]          w_last_cnt;
  logic                   w_close;
  logic signed [SUMW-1:0] w_round;
  logic signed [SUMW-1:0] w_sum;
  logic signed [SUMW-1:0] w_avg;
  logic signed [DW-1:0]   w_avg_sat;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_wr;
  logic                   w_drop;

  // ------------------------------------------------------------------------
  // Decimator
  // ------------------------------------------------------------------------

  // The first en of a block uses the live shift input; later ens of the same
  // block use the value captured at that first en.
  assign w_shift_eff = (r_cnt == '0) ? shift : r_shift;

  // R-1 as a CW-bit mask: shift=0 -> 0, shift=CW -> all ones.
  assign w_last_cnt  = ~({CW{1'b1}} << w_shift_eff);

  assign w_close     = en && (r_cnt == w_last_cnt);

  assign w_round     = (w_shift_eff == '0) ? '0
                                           : (SUMW'(1) << (w_shift_eff - SW'(1)));

  assign w_sum       = SUMW'(r_acc) + SUMW'(in) + w_round;
  assign w_avg       = w_sum >>> w_shift_eff;

  always_comb begin
    w_avg_sat = w_avg[DW-1:0];
    if (w_avg > SAT_MAX) begin
      w_avg_sat = SAT_MAX[DW-1:0];
    end else if (w_avg < SAT_MIN) begin
      w_avg_sat = SAT_MIN[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (en) begin
      if (r_cnt == '0) begin
        r_shift <= shift;
      end
      if (w_close) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= r_acc + ACCW'(in);
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // ------------------------------------------------------------------------
  // Output FIFO
  // ------------------------------------------------------------------------

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;

  // A full FIFO still accepts a push when the head leaves in the same cycle;
  // the write then lands in the slot being vacated.
  assign w_wr      = w_close && (!w_full || w_pop);
  assign w_drop    = w_close && w_full && !w_pop;

  assign out_data  = r_mem[r_rptr[AW-1:0]];
  assign level     = r_wptr - r_rptr;
  assign ovf       = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
    end
  end

  // Storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (!rst && w_wr) begin
      r_mem[r_wptr[AW-1:0]] <= w_avg_sat;
    end
  end

  // A drop in the same cycle as clr_ovf wins so that no loss goes unreported.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

`ifdef DECIM_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (clr_ovf) begin
      r_drop_cnt <= w_drop ? 16'd1 : 16'd0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_decim_buffer.sv
// tb/tb_decim_buffer.sv - scoreboard bench for decim_buffer
module tb_decim_buffer;

  localparam int DW    = 10;
  localparam int SW    = 3;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic signed [DW-1:0] in;
  logic [SW-1:0]        shift;
  logic                 clr_ovf;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [AW:0]          level;
  logic                 ovf;
`ifdef DECIM_DROP_CNT_EN
  logic [15:0]          drop_cnt;
`endif

  int     n_chk = 0;
  int     n_err = 0;
  int     exp_q[$];
  longint m_acc;
  int     m_cnt;
  int     m_shift;
  bit     m_ovf;
  int     m_dc;
  bit     mon_en = 1'b0;

  decim_buffer #(.DW(DW), .SW(SW), .AW(AW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in        (in),
    .shift     (shift),
    .clr_ovf   (clr_ovf),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
`ifdef DECIM_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge, using the inputs presented to it.
  task automatic model_edge();
    bit     drop;
    longint s;
    longint avg;
    drop = 1'b0;
    if (rst) begin
      m_acc = 0; m_cnt = 0; m_shift = 0; m_ovf = 1'b0; m_dc = 0;
      exp_q.delete();
      return;
    end
    if (en) begin
      if (m_cnt == 0) m_shift = int'(shift);
      s = m_acc + longint'(in);
      if (m_cnt == (1 << m_shift) - 1) begin
        avg = s + ((m_shift > 0) ? (longint'(1) << (m_shift - 1)) : 0);
        avg = avg >>> m_shift;
        if (avg > 511)  avg = 511;
        if (avg < -512) avg = -512;
        if (exp_q.size() >= DEPTH) drop = 1'b1;
        else exp_q.push_back(int'(avg));
        m_acc = 0;
        m_cnt = 0;
      end else begin
        m_acc = s;
        m_cnt++;
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    if (clr_ovf) m_dc = drop ? 1 : 0;
    else if (drop && m_dc < 65535) m_dc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    en      = 1'b0;
    clr_ovf = 1'b0;
  endtask

  task automatic send(input int v);
    en = 1'b1;
    in = DW'(v);
    tick();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    tick();
    tick();
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // Per-cycle comparison of DUT state against the model, plus head pops.
  always @(negedge clk) begin
    if (mon_en) begin
      check("level", level, exp_q.size());
      check("out_valid", out_valid, exp_q.size() != 0);
      check("ovf", ovf, m_ovf);
`ifdef DECIM_DROP_CNT_EN
      check("drop_cnt", drop_cnt, m_dc);
`endif
      if (out_valid && out_ready && exp_q.size() != 0)
        check("out_data", out_data, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; in = DW'(100); shift = '0; clr_ovf = 1'b0;
    out_ready = 1'b0;
    tick();
    mon_en = 1'b1;
    en = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_level", level, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ovf", ovf, 0);

    // Pass-through with shift=0, one result per en
    shift = '0;
    out_ready = 1'b1;
    send(5);  @(negedge clk); check("pass_5", out_data, 5);
    send(-3); @(negedge clk); check("pass_m3", out_data, -3);
    send(7);  @(negedge clk); check("pass_7", out_data, 7);
    drain();

    // Averaging by 4 with rounding
    shift = 3'd2;
    out_ready = 1'b0;
    send(1); send(2); send(3); send(4);
    @(negedge clk); check("avg4_pos", out_data, 3);
    send(-1); send(-1); send(-1); send(-2);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    @(negedge clk); check("avg4_neg", out_data, -1);
    drain();

    // Full-scale blocks of 8 must not wrap
    shift = 3'd3;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(511);
    @(negedge clk); check("fullscale_pos", out_data, 511);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(-512);
    @(negedge clk); check("fullscale_neg", out_data, -512);
    drain();

    // Shift change mid-block only applies to the next block
    out_ready = 1'b1;
    shift = 3'd2; send(4);
    shift = 3'd0; send(4); send(4); send(8);
    send(9);
    drain();

    // Overflow: ten results into an eight-deep FIFO with no consumer
    shift = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(i * 10 + 1);
    @(negedge clk);
    check("ovf_level", level, 8);
    check("ovf_flag", ovf, 1);
`ifdef DECIM_DROP_CNT_EN
    check("ovf_drop_cnt", drop_cnt, 2);
`endif
    clr_ovf = 1'b1; send(99);
    @(negedge clk);
    check("clr_vs_drop_ovf", ovf, 1);
`ifdef DECIM_DROP_CNT_EN
    check("clr_vs_drop_cnt", drop_cnt, 1);
`endif
    clr_ovf = 1'b1; tick();
    @(negedge clk);
    check("clr_ovf", ovf, 0);

    // Full FIFO with simultaneous push and pop
    out_ready = 1'b1; send(123); out_ready = 1'b0;
    @(negedge clk);
    check("full_pushpop_level", level, 8);
    check("full_pushpop_ovf", ovf, 0);
    drain();

    // Reset mid-block discards the partial sum and FIFO contents
    out_ready = 1'b0;
    shift = '0; send(50);
    shift = 3'd2; send(3); send(3);
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk); check("midrst_level", level, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(8);
    @(negedge clk); check("midrst_out", out_data, 8);
    drain();

    // Randomised traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) shift = SW'($urandom_range(0, 3));
      en        = ($urandom_range(0, 3) != 0);
      in        = DW'($urandom_range(0, 1023));
      out_ready = ($urandom_range(0, 2) != 0);
      clr_ovf   = ($urandom_range(0, 31) == 0);
      tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
